// File: rtl/shumezuesi24_sekuencial.sv
// Sequential 24x24 -> 48 shift-add multiplier.
// Reuses the external 24-bit ripple adder, one add per cycle.
module shumezuesi24_sekuencial #(
  parameter int WIDTH = 24,
  parameter int CNT_W = 5
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  output logic [WIDTH-1:0]   add_a,
  output logic [WIDTH-1:0]   add_b,
  input  logic [WIDTH-1:0]   add_sum,
  input  logic               add_cout,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic               ovf
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [CNT_W-1:0] cnt;
  logic             load;
  logic             last;

  assign ready = (state == IDLE) || (state == DONE);
  assign busy  = (state == BUSY);
  assign load  = ready && start;
  assign last  = busy && (cnt == CNT_W'(WIDTH - 1));

  assign add_a = hi;
  assign add_b = lo[0] ? a_reg : '0;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = BUSY;
      BUSY:    if (last) state_nx = DONE;
      DONE:    state_nx = start ? BUSY : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_reg   <= '0;
      hi      <= '0;
      lo      <= '0;
      cnt     <= '0;
      product <= '0;
      ovf     <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= last;
      if (load) begin
        a_reg <= op_a;
        lo    <= op_b;
        hi    <= '0;
        cnt   <= '0;
      end else if (busy) begin
        hi  <= {add_cout, add_sum[WIDTH-1:1]};
        lo  <= {add_sum[0], lo[WIDTH-1:1]};
        cnt <= cnt + CNT_W'(1);
      end
      // Upper half of the final shift is {cout, sum[23:1]}
      if (last) begin
        product <= {add_cout, add_sum, lo[WIDTH-1:1]};
        ovf     <= add_cout | (|add_sum[WIDTH-1:1]);
      end
    end
  end

endmodule

// File: tb/tb_shumezuesi24_sekuencial.sv
// Directed bench for the sequential multiplier.
// Adder modelled here; products scoreboarded against a*b.
module tb_shumezuesi24_sekuencial;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [23:0] op_a;
  logic [23:0] op_b;
  logic [23:0] add_a;
  logic [23:0] add_b;
  logic [23:0] add_sum;
  logic        add_cout;
  logic        ready;
  logic        busy;
  logic        done;
  logic [47:0] product;
  logic        ovf;

  logic [24:0] sum_full;

  int checks = 0;
  int failures = 0;

  logic [47:0] sb[$];
  logic [47:0] last_prod;
  logic [23:0] m_a;
  logic [23:0] m_hi;
  logic [23:0] m_lo;

  always #5 clk = ~clk;

  assign sum_full = {1'b0, add_a} + {1'b0, add_b};
  assign add_sum  = sum_full[23:0];
  assign add_cout = sum_full[24];

  shumezuesi24_sekuencial dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .op_a     (op_a),
    .op_b     (op_b),
    .add_a    (add_a),
    .add_b    (add_b),
    .add_sum  (add_sum),
    .add_cout (add_cout),
    .ready    (ready),
    .busy     (busy),
    .done     (done),
    .product  (product),
    .ovf      (ovf)
  );

  task automatic check(input string tag,
                       input logic [47:0] got,
                       input logic [47:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, got, exp);
    end
  endtask

  // Drive start at the current negedge; released one cycle later.
  task automatic launch(input logic [23:0] a,
                        input logic [23:0] b);
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    sb.push_back(48'(a) * 48'(b));
    m_a  = a;
    m_hi = '0;
    m_lo = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic finish(input int pulse_at,
                        input int abort_at);
    int n;
    logic [24:0] t;
    logic [23:0] eb;
    logic [47:0] exp;
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      if (n == pulse_at) begin
        start = 1'b1;
        op_a  = 24'd2;
        op_b  = 24'd2;
      end else if (n == pulse_at + 1) begin
        start = 1'b0;
      end
      if (n == abort_at) begin
        reset_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_product", product, 0);
        check("abort_ovf", ovf, 0);
        check("abort_ready", ready, 1);
        if (sb.size() > 0) void'(sb.pop_front());
        last_prod = '0;
        return;
      end
      eb = m_lo[0] ? m_a : 24'd0;
      check("busy_high", busy, 1);
      check("add_a", add_a, m_hi);
      check("add_b", add_b, eb);
      check("product_hold", product, last_prod);
      t = {1'b0, m_hi} + {1'b0, eb};
      {m_hi, m_lo} = {t, m_lo[23:1]};
      n++;
      @(negedge clk);
    end
    exp = (sb.size() > 0) ? sb.pop_front() : 48'hx;
    check("latency", 48'(n), 48'd24);
    check("done_ready", ready, 1);
    check("product", product, exp);
    check("ovf", ovf, 48'(exp[47:24] != 0));
    last_prod = exp;
  endtask

  initial begin
    int dcount;
    reset_n   = 1'b0;
    start     = 1'b0;
    op_a      = '0;
    op_b      = '0;
    last_prod = '0;
    repeat (2) @(negedge clk);
    check("rst_ready", ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_product", product, 0);
    check("rst_ovf", ovf, 0);
    reset_n = 1'b1;
    @(negedge clk);

    launch(24'd3, 24'd5);
    finish(-1, -1);
    @(negedge clk);
    check("done_pulse", done, 0);
    check("idle_ready", ready, 1);

    launch(24'hFFFFFF, 24'hFFFFFF);
    finish(-1, -1);
    @(negedge clk);

    launch(24'h001000, 24'h001000);
    finish(-1, -1);
    @(negedge clk);

    launch(24'h000000, 24'hABCDEF);
    finish(-1, -1);
    @(negedge clk);

    launch(24'd7, 24'd9);
    finish(10, -1);
    launch(24'd2, 24'd2);
    finish(-1, -1);
    @(negedge clk);
    check("b2b_done_pulse", done, 0);

    launch(24'h123456, 24'h000010);
    finish(-1, 12);
    @(negedge clk);
    reset_n = 1'b1;
    dcount = 0;
    repeat (30) begin
      @(negedge clk);
      if (done === 1'b1) dcount++;
    end
    check("no_spurious_done", 48'(dcount), 0);
    check("post_rst_ready", ready, 1);

    launch(24'h123456, 24'h000010);
    finish(-1, -1);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/shumezuesi24_sekuencial.md
Name: shumezuesi24_sekuencial

Overview:
- Multi-cycle unsigned 24x24 -> 48-bit shift-add multiplier for the 24-bit CPU datapath.
- Has no internal adder. Each cycle it feeds one operand pair to the existing 24-bit ripple adder and registers that adder's sum and carry-out. It therefore sits directly upstream and downstream of the adder.
- It issues one add per cycle and produces its result after a fixed 24-cycle latency, with a start/done handshake to the control unit.

Parameters:
- WIDTH, 24, operand width. The design is fixed at 24 to match the adder; other values are unsupported.
- CNT_W, 5, iteration counter width. Must satisfy 2^CNT_W >= WIDTH.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  request to begin a multiply; sampled only when ready=1.
- op_a  input  24  multiplicand; captured when start is accepted.
- op_b  input  24  multiplier; captured when start is accepted.
- add_a  output  24  adder operand a; combinational from hi register.
- add_b  output  24  adder operand b; combinational, equals a_reg if lo[0]=1 else 0.
- add_sum  input  24  adder sum result.
- add_cout  input  1  adder carry-out.
- ready  output  1  high when state is IDLE or DONE.
- busy  output  1  high when state is BUSY.
- done  output  1  one-cycle pulse when product becomes valid.
- product  output  48  registered result; held until the next completion.
- ovf  output  1  registered; 1 when product[47:24] != 0. Updated together with product.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE, a_reg=0, hi=0, lo=0, cnt=0.
  - product=0, ovf=0, done=0, busy=0, ready=1.
  - Reset asserted mid-operation aborts that operation immediately; no done is issued for it.
- State IDLE:
  - ready=1.
  - On an edge with start=1: a_reg<=op_a, lo<=op_b, hi<=0, cnt<=0, go to BUSY.
- State BUSY, one iteration per edge:
  - hi <= add_sum[23:1] with add_cout as the new MSB, i.e. {add_cout, add_sum[23:1]}.
  - lo <= {add_sum[0], lo[23:1]}.
  - cnt <= cnt+1.
  - When lo[0]=0, add_b=0, so add_sum=hi and add_cout=0. This is a plain shift.
  - On the edge where cnt==23:
    - product <= {add_cout, add_sum, lo[23:1]}; ovf computed from that value.
    - done<=1, go to DONE.
  - start is ignored while in BUSY; op_a/op_b changes have no effect.
- State DONE:
  - Lasts exactly one cycle; done=1, ready=1.
  - With start=1 on that edge: load new operands, go to BUSY (back-to-back operation, no idle bubble), done<=0.
  - Otherwise go to IDLE, done<=0.
- Latency: start accepted at edge k, done=1 during the cycle following edge k+24. Throughput is one multiply per 25 cycles.
- product/ovf hold their value through IDLE and the whole next BUSY phase. They change only at completion.
- Arithmetic: unsigned only. The 48-bit result is exact; no truncation. ovf flags any result not representable in 24 bits.
- Boundaries:
  - op_b=0 or op_a=0 still takes the full 24 cycles and yields product=0, ovf=0.
  - The adder path is combinational, so add_a/add_b must be stable from the state registers, with no dependence on start or op_*.

Test Plan:
- Reset, then start with op_a=3, op_b=5 -> done after 24 cycles; product=0x000000_00000F, ovf=0; busy high for exactly 24 cycles.
- op_a=0xFFFFFF, op_b=0xFFFFFF -> product=0xFFFFFE000001, ovf=1.
- op_a=0x001000, op_b=0x001000 -> product=0x000001000000, ovf=1. Then op_a=0, op_b=0xABCDEF -> product=0, ovf=0, and the full 24-cycle latency is observed.
- Start with 7x9; pulse start with op_a=2, op_b=2 at BUSY cycle 10 -> ignored; product=63 (0x3F). Hold start high in the DONE cycle with 2x2 -> next done exactly 24 cycles later, product=4, and product stays 63 until then.
- Assert reset_n=0 mid-BUSY (cycle 12 of 0x123456 x 0x10) -> busy, done, product and ovf go to 0 immediately. After release, ready=1 and no spurious done occurs.
- Every BUSY cycle, check add_a==hi and add_b==(lo[0] ? a_reg : 0) against a reference model connected to the real 24-bit adder.
